// File: rtl/backprop_sequencer.sv
`timescale 1ns/1ps
// backprop_sequencer
//   Control sequencer for one backpropagation pass through a layered network.
//   Walks the layers from the output layer down to layer 1. For every layer it
//   requests that layer's weights, issues one delta operation per neuron and
//   then one weight-update operation per neuron on a shared datapath.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   start        : request a pass (accepted only in IDLE, DONE or ERR)
//   neuron_count : packed 32-bit neuron counts, slice 0 = input layer
//   wt_ready     : weights for wt_layer are loaded
//   dp_done      : datapath finished the current operation
//   wt_req       : level request for weights_<wt_layer>
//   wt_layer     : weight file index (layer_idx-1)
//   dp_start     : one-cycle datapath launch pulse
//   dp_mode      : 0 output delta, 1 hidden delta, 2 weight update
//   layer_idx    : target layer of the current operation
//   neuron_idx   : target neuron of the current operation
//   vlen         : vector length of the current operation
//   busy         : a pass is in progress
//   finished     : the last pass completed
//   error        : the last pass stopped on an invalid neuron count
module backprop_sequencer #(
    parameter int NR_LAYERS  = 2,
    parameter int MAXRESULTS = 15,
    parameter int MAXWEIGHTS = 784
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [32*(NR_LAYERS+1)-1:0]   neuron_count,
    input  logic                          wt_ready,
    input  logic                          dp_done,
    output logic                          wt_req,
    output logic [31:0]                   wt_layer,
    output logic                          dp_start,
    output logic [1:0]                    dp_mode,
    output logic [31:0]                   layer_idx,
    output logic [31:0]                   neuron_idx,
    output logic [31:0]                   vlen,
    output logic                          busy,
    output logic                          finished,
    output logic                          error
);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, ISSUE_D, WAIT_D, ISSUE_U, WAIT_U, DONE, ERR
    } state_t;

    state_t                        state, state_nx;
    logic [32*(NR_LAYERS+1)-1:0]   counts;
    logic [31:0]                   layer_nx, neuron_nx;
    logic                          load_counts;
    logic [31:0]                   cnt_cur, cnt_in, cnt_out;
    logic                          count_bad, more_neurons;

    // Bounds-safe lookup: indices outside 0..NR_LAYERS read as zero.
    function automatic logic [31:0] count_at(input logic [32*(NR_LAYERS+1)-1:0] c,
                                             input logic [31:0] idx);
        count_at = '0;
        for (int i = 0; i <= NR_LAYERS; i++) begin
            if (idx == 32'(i)) count_at = c[32*i +: 32];
        end
    endfunction

    // Counts come from the copy latched at start, so live input changes
    // cannot disturb a pass in progress.
    assign cnt_cur      = count_at(counts, layer_idx);
    assign cnt_in       = count_at(counts, layer_idx - 32'd1);
    assign cnt_out      = count_at(counts, layer_idx + 32'd1);
    assign count_bad    = (cnt_cur == 32'd0) || (cnt_cur > 32'(MAXRESULTS)) ||
                          (cnt_in == 32'd0)  || (cnt_in > 32'(MAXWEIGHTS));
    assign more_neurons = (neuron_idx + 32'd1) < cnt_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            layer_idx  <= '0;
            neuron_idx <= '0;
            counts     <= '0;
        end else begin
            state      <= state_nx;
            layer_idx  <= layer_nx;
            neuron_idx <= neuron_nx;
            if (load_counts) counts <= neuron_count;
        end
    end

    always_comb begin
        state_nx    = state;
        layer_nx    = layer_idx;
        neuron_nx   = neuron_idx;
        load_counts = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx    = LOAD_W;
                    layer_nx    = 32'(NR_LAYERS);
                    neuron_nx   = '0;
                    load_counts = 1'b1;
                end
            end
            LOAD_W: begin
                // Count validation wins over a simultaneous wt_ready.
                if (count_bad)     state_nx = ERR;
                else if (wt_ready) state_nx = ISSUE_D;
            end
            ISSUE_D: state_nx = WAIT_D;
            WAIT_D: begin
                if (dp_done) begin
                    if (more_neurons) begin
                        neuron_nx = neuron_idx + 32'd1;
                        state_nx  = ISSUE_D;
                    end else begin
                        neuron_nx = '0;
                        state_nx  = ISSUE_U;
                    end
                end
            end
            ISSUE_U: state_nx = WAIT_U;
            WAIT_U: begin
                if (dp_done) begin
                    if (more_neurons) begin
                        neuron_nx = neuron_idx + 32'd1;
                        state_nx  = ISSUE_U;
                    end else if (layer_idx == 32'd1) begin
                        state_nx  = DONE;
                    end else begin
                        layer_nx  = layer_idx - 32'd1;
                        neuron_nx = '0;
                        state_nx  = LOAD_W;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wt_req   = (state == LOAD_W);
        dp_start = (state == ISSUE_D) || (state == ISSUE_U);
        busy     = !((state == IDLE) || (state == DONE) || (state == ERR));
        finished = (state == DONE);
        error    = (state == ERR);
        // Guarded so the reset value of layer_idx maps to 0, not all-ones.
        wt_layer = (layer_idx == 32'd0) ? 32'd0 : layer_idx - 32'd1;
        dp_mode  = 2'd0;
        vlen     = '0;
        // Mode and length are a function of state and layer only, so they
        // cannot move between dp_start and the accepting dp_done.
        case (state)
            ISSUE_D, WAIT_D: begin
                if (layer_idx == 32'(NR_LAYERS)) begin
                    dp_mode = 2'd0;
                    vlen    = 32'd1;
                end else begin
                    dp_mode = 2'd1;
                    vlen    = cnt_out;
                end
            end
            ISSUE_U, WAIT_U: begin
                dp_mode = 2'd2;
                vlen    = cnt_in;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_backprop_sequencer.sv
`timescale 1ns/1ps
// Testbench for backprop_sequencer: a responder plays weight memory and
// datapath, and each scenario task compares the observed operation stream,
// status and timing against a layer/neuron model of the pass.
module tb_backprop_sequencer;
    localparam int NL = 2;

    logic              clk = 1'b0;
    logic              rst, start, wt_ready, dp_done;
    logic [32*(NL+1)-1:0] neuron_count;
    logic              wt_req, dp_start, busy, finished, error;
    logic [31:0]       wt_layer, layer_idx, neuron_idx, vlen;
    logic [1:0]        dp_mode;

    backprop_sequencer #(.NR_LAYERS(NL), .MAXRESULTS(15), .MAXWEIGHTS(784)) dut (
        .clk(clk), .rst(rst), .start(start), .neuron_count(neuron_count),
        .wt_ready(wt_ready), .dp_done(dp_done), .wt_req(wt_req), .wt_layer(wt_layer),
        .dp_start(dp_start), .dp_mode(dp_mode), .layer_idx(layer_idx),
        .neuron_idx(neuron_idx), .vlen(vlen), .busy(busy), .finished(finished),
        .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] layer;
        logic [31:0] neuron;
        logic [31:0] vlen;
    } op_t;

    op_t obs_q[$];
    op_t exp_q[$];
    int  wtl_q[$];
    int  wlen_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wt_delay = 0;
    int  dd_delay = 1;
    bit  stray = 0;
    bit  dd_force = 0;
    int  ev_cyc = -1;
    int  stab_err = 0;
    int  start_in_wreq = 0;
    int  exp_lat;
    bit  exp_err;

    // Responder and observer for weight memory and datapath.
    initial begin : responder
        int  wcnt, dcnt, wlen;
        bit  in_op, prev_wr, prev_ev;
        op_t cap, cur;
        wcnt = 0; dcnt = 0; wlen = 0; in_op = 0; prev_wr = 0; prev_ev = 0;
        cap = '0;
        wt_ready = 1'b0;
        dp_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_op = 0; dcnt = 0; wcnt = 0; wlen = 0; prev_wr = 0; prev_ev = 0;
                wt_ready = 1'b0;
                dp_done  = dd_force;
                continue;
            end
            cur = {dp_mode, layer_idx, neuron_idx, vlen};
            if (dp_start && wt_req) start_in_wreq++;
            if (wt_req && !prev_wr) wtl_q.push_back(int'(wt_layer));
            if (wt_req) wlen++;
            else if (prev_wr) begin wlen_q.push_back(wlen); wlen = 0; end
            prev_wr = wt_req;
            if ((finished || error) && !prev_ev) ev_cyc = cyc;
            prev_ev = finished || error;
            if (in_op && !dp_start && cur !== cap) stab_err++;
            wt_ready = wt_req && (wcnt >= wt_delay);
            wcnt = wt_req ? wcnt + 1 : 0;
            dp_done = 1'b0;
            if (dp_start) begin
                obs_q.push_back(cur);
                cap = cur; in_op = 1; dcnt = dd_delay;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin dp_done = 1'b1; in_op = 0; end
            end
            if (stray && (dp_start || !busy)) dp_done = 1'b1;
            if (dd_force) dp_done = 1'b1;
        end
    end

    // Reference model: walk layers top-down, listing every operation and
    // the cycle (relative to the start cycle) at which finished/error rises.
    task automatic build_model(input int c[3], input int wtd, input int dd);
        op_t o;
        exp_q.delete();
        exp_err = 0;
        exp_lat = 1;
        for (int l = NL; l >= 1; l--) begin
            exp_lat += 1;
            if (c[l] == 0 || c[l] > 15 || c[l-1] == 0 || c[l-1] > 784) begin
                exp_err = 1;
                break;
            end
            exp_lat += wtd;
            for (int n = 0; n < c[l]; n++) begin
                o.mode   = (l == NL) ? 2'd0 : 2'd1;
                o.layer  = 32'(l);
                o.neuron = 32'(n);
                o.vlen   = (l == NL) ? 32'd1 : 32'(c[(l < NL) ? l + 1 : l]);
                exp_q.push_back(o);
            end
            for (int n = 0; n < c[l]; n++) begin
                o.mode = 2'd2; o.layer = 32'(l); o.neuron = 32'(n); o.vlen = 32'(c[l-1]);
                exp_q.push_back(o);
            end
            exp_lat += 2 * c[l] * (1 + dd);
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic set_counts(input int c[3]);
        for (int i = 0; i <= NL; i++) neuron_count[32*i +: 32] = 32'(c[i]);
    endtask

    task automatic pulse_start(output int sc);
        @(negedge clk);
        obs_q.delete(); wtl_q.delete(); wlen_q.delete();
        ev_cyc = -1; stab_err = 0; start_in_wreq = 0;
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && (finished || error)) begin to = 0; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; neuron_count = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wt_req, wt_layer, dp_start, dp_mode, layer_idx, neuron_idx, vlen,
             busy, finished, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b fin=%b err=%b layer=%0d vlen=%0d, required all zero",
                     busy, finished, error, layer_idx, vlen);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b starts=%0d, required busy=0 starts=0", busy, obs_q.size());
        end
    endtask

    task automatic test_nominal();
        int  c[3] = '{3, 2, 2};
        op_t nom[8];
        int  sc;
        bit  to;
        nom = '{ {2'd0, 32'd2, 32'd0, 32'd1}, {2'd0, 32'd2, 32'd1, 32'd1},
                 {2'd2, 32'd2, 32'd0, 32'd2}, {2'd2, 32'd2, 32'd1, 32'd2},
                 {2'd1, 32'd1, 32'd0, 32'd2}, {2'd1, 32'd1, 32'd1, 32'd2},
                 {2'd2, 32'd1, 32'd0, 32'd3}, {2'd2, 32'd1, 32'd1, 32'd3} };
        set_counts(c);
        pulse_start(sc);
        neuron_count = '1;   // live change after start must not matter
        wait_end(500, to);
        set_counts(c);
        checks++;
        if (to || obs_q.size() != 8) begin
            errors++;
            $display("FAIL nominal_count: got %0d starts (timeout=%0d), required 8", obs_q.size(), to);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== nom[i]) begin
                    errors++;
                    $display("FAIL nominal_op%0d: got mode=%0d layer=%0d neuron=%0d vlen=%0d, required %0d/%0d/%0d/%0d",
                             i, obs_q[i].mode, obs_q[i].layer, obs_q[i].neuron, obs_q[i].vlen,
                             nom[i].mode, nom[i].layer, nom[i].neuron, nom[i].vlen);
                end
            end
        end
        checks++;
        if (wtl_q.size() != 2 || wtl_q[0] != 1 || wtl_q[1] != 0) begin
            errors++;
            $display("FAIL nominal_wt_layer: got %0d loads first=%0d, required 1 then 0",
                     wtl_q.size(), (wtl_q.size() > 0) ? wtl_q[0] : -1);
        end
        checks++;
        if (ev_cyc - sc != 19 || finished !== 1'b1) begin
            errors++;
            $display("FAIL nominal_latency: got %0d cycles finished=%b, required 19 and 1", ev_cyc - sc, finished);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL nominal_stable: got %0d output changes during waits, required 0", stab_err);
        end
    endtask

    task automatic test_wt_stall();
        int c[3] = '{3, 2, 2};
        int sc;
        bit to;
        wt_delay = 5;
        set_counts(c);
        build_model(c, 5, 1);
        pulse_start(sc);
        wait_end(500, to);
        checks++;
        if (to || first_diff() != -1) begin
            errors++;
            $display("FAIL wt_stall_ops: got first difference at %0d (timeout=%0d), required none", first_diff(), to);
        end
        checks++;
        if (wlen_q.size() != 2 || wlen_q[0] != 6 || wlen_q[1] != 6) begin
            errors++;
            $display("FAIL wt_stall_req_len: got %0d loads first=%0d, required 2 loads of 6 cycles",
                     wlen_q.size(), (wlen_q.size() > 0) ? wlen_q[0] : -1);
        end
        checks++;
        if (start_in_wreq != 0) begin
            errors++;
            $display("FAIL wt_stall_start: got %0d dp_start during wt_req, required 0", start_in_wreq);
        end
        checks++;
        if (ev_cyc - sc != 29) begin
            errors++;
            $display("FAIL wt_stall_latency: got %0d, required 29", ev_cyc - sc);
        end
        wt_delay = 0;
    endtask

    task automatic test_dp_stall();
        int c[3] = '{3, 2, 2};
        int sc;
        bit to;
        dd_delay = 7; stray = 1;
        set_counts(c);
        build_model(c, 0, 7);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || obs_q.size() != 8) begin
            errors++;
            $display("FAIL dp_stall_idle: got busy=%b, required 0", busy);
        end
        pulse_start(sc);
        wait_end(1000, to);
        checks++;
        if (to || obs_q.size() != 8 || first_diff() != -1) begin
            errors++;
            $display("FAIL dp_stall_ops: got %0d starts, first difference %0d, required 8 and none",
                     obs_q.size(), first_diff());
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL dp_stall_stable: got %0d changes, required 0", stab_err);
        end
        checks++;
        if (ev_cyc - sc != exp_lat) begin
            errors++;
            $display("FAIL dp_stall_latency: got %0d, required %0d", ev_cyc - sc, exp_lat);
        end
        dd_delay = 1; stray = 0;
    endtask

    task automatic test_error();
        int c[3] = '{0, 2, 2};
        int g[3] = '{3, 2, 2};
        int sc;
        bit to;
        set_counts(c);
        build_model(c, 0, 1);
        pulse_start(sc);
        wait_end(500, to);
        checks++;
        if (to || error !== 1'b1 || finished !== 1'b0) begin
            errors++;
            $display("FAIL error_flag: got error=%b finished=%b, required 1 and 0", error, finished);
        end
        checks++;
        if (obs_q.size() != 4 || first_diff() != -1) begin
            errors++;
            $display("FAIL error_ops: got %0d starts, required 4 from layer 2 only", obs_q.size());
        end
        checks++;
        if (ev_cyc - sc != exp_lat) begin
            errors++;
            $display("FAIL error_latency: got %0d, required %0d", ev_cyc - sc, exp_lat);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != 4 || error !== 1'b1) begin
            errors++;
            $display("FAIL error_hold: got %0d starts error=%b, required 4 and 1", obs_q.size(), error);
        end
        set_counts(g);
        pulse_start(sc);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL error_clear: got error=%b busy=%b, required 0 and 1", error, busy);
        end
        wait_end(500, to);
        checks++;
        if (to || finished !== 1'b1) begin
            errors++;
            $display("FAIL error_recover: got finished=%b, required 1", finished);
        end
    endtask

    task automatic test_boundaries();
        int tab[3][3] = '{ '{784, 15, 1}, '{3, 2, 16}, '{785, 2, 2} };
        int c[3];
        int sc;
        bit to;
        for (int k = 0; k < 3; k++) begin
            c = tab[k];
            set_counts(c);
            build_model(c, 0, 1);
            pulse_start(sc);
            wait_end(2000, to);
            checks++;
            if (to || first_diff() != -1 || error !== exp_err || finished !== !exp_err ||
                ev_cyc - sc != exp_lat) begin
                errors++;
                $display("FAIL boundary%0d: got starts=%0d err=%b lat=%0d, required starts=%0d err=%0d lat=%0d",
                         k, obs_q.size(), error, ev_cyc - sc, exp_q.size(), exp_err, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  c[3] = '{3, 2, 2};
        int  sc, n2, nobs;
        bit  to;
        dd_delay = 3;
        set_counts(c);
        pulse_start(sc);
        n2 = 0;
        to = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            n2 = 0;
            foreach (obs_q[j]) if (obs_q[j].mode == 2'd2) n2++;
            if (n2 >= 3) begin to = 0; break; end
        end
        @(negedge clk); #1;
        rst = 1'b1; dd_force = 1;
        #1;
        checks++;
        if (to || {wt_req, wt_layer, dp_start, dp_mode, layer_idx, neuron_idx, vlen,
                   busy, finished, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b layer=%0d vlen=%0d (timeout=%0d), required all zero",
                     busy, layer_idx, vlen, to);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nobs = obs_q.size();
        repeat (2) @(negedge clk);
        dd_force = 0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || obs_q.size() != nobs) begin
            errors++;
            $display("FAIL reset_mid_idle: got busy=%b finished=%b new starts=%0d, required 0/0/0",
                     busy, finished, obs_q.size() - nobs);
        end
        dd_delay = 1;
    endtask

    task automatic test_start_busy();
        int c[3] = '{3, 2, 2};
        int sc;
        bit to;
        set_counts(c);
        build_model(c, 0, 1);
        pulse_start(sc);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(500, to);
        checks++;
        if (to || first_diff() != -1 || ev_cyc - sc != 19) begin
            errors++;
            $display("FAIL start_busy_pass: got starts=%0d lat=%0d, required 8 and 19", obs_q.size(), ev_cyc - sc);
        end
        pulse_start(sc);
        wait_end(500, to);
        checks++;
        if (to || first_diff() != -1 || ev_cyc - sc != 19 || finished !== 1'b1) begin
            errors++;
            $display("FAIL start_done_pass: got starts=%0d lat=%0d, required 8 and 19", obs_q.size(), ev_cyc - sc);
        end
    endtask

    task automatic test_random();
        int c[3];
        int sc, wtd, dd;
        bit to;
        for (int it = 0; it < 8; it++) begin
            c[0] = $urandom_range(1, 6);
            c[1] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 4);
            c[2] = $urandom_range(1, 4);
            wtd  = $urandom_range(0, 3);
            dd   = $urandom_range(1, 4);
            wt_delay = wtd; dd_delay = dd;
            set_counts(c);
            build_model(c, wtd, dd);
            pulse_start(sc);
            wait_end(3000, to);
            checks++;
            if (to || first_diff() != -1 || error !== exp_err || ev_cyc - sc != exp_lat ||
                stab_err != 0) begin
                errors++;
                $display("FAIL random%0d: counts %0d/%0d/%0d got starts=%0d err=%b lat=%0d, required starts=%0d err=%0d lat=%0d",
                         it, c[0], c[1], c[2], obs_q.size(), error, ev_cyc - sc,
                         exp_q.size(), exp_err, exp_lat);
            end
        end
        wt_delay = 0; dd_delay = 1;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wt_stall();
        test_dp_stall();
        test_error();
        test_boundaries();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
